uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter with 5..9 data bits, optional parity, 1 or 2 stop bits.
// One word per valid/ready handshake; txd and ready are registered.
module uart_tx_frame #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int BPS       = 9_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DATA_BITS-1:0] uart_tx_data,
  input  logic                 uart_tx_valid,
  output logic                 uart_tx_ready,
  output logic                 uart_tx_busy,
  output logic                 uart_tx_done,
  output logic                 uart_txd
);

  localparam int BPS_CNT = CLK_FRE / BPS;
  localparam int CW      = $clog2(BPS_CNT);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || BPS_CNT < 2) begin : g_bad_cfg
    $error("uart_tx_frame: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (clk_cnt_q == CW'(BPS_CNT - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    txd_d     = txd_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (state_q == IDLE) begin
      if (uart_tx_valid && ready_q) begin
        shift_d   = uart_tx_data;
        par_d     = (PARITY == 1) ? ~^uart_tx_data : ^uart_tx_data;
        state_d   = START;
        txd_d     = 1'b0;
        ready_d   = 1'b0;
        busy_d    = 1'b1;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    end else if (!bit_end) begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end else begin
      // Bit period over: the next bit level is driven on this same edge.
      clk_cnt_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
        end
        DATA: begin
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
        PAR: begin
          state_d   = STOP;
          txd_d     = 1'b1;
          bit_cnt_d = '0;
        end
        STOP: begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
            txd_d     = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign uart_txd      = txd_q;
  assign uart_tx_ready = ready_q;
  assign uart_tx_busy  = busy_q;
  assign uart_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame over four configurations.
// Expected line levels are queued per frame and popped bit by bit as the DUT shifts.
module tb_uart_tx_frame;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] data    = 8'h00;
  logic [3:0] valid_v = 4'b0000;
  logic [3:0] txd_w, ready_w, busy_w, done_w;
  int         sel = 0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         exp_q[$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2 -- all at BPS_CNT = 10
  uart_tx_frame #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_tx_data(data), .uart_tx_valid(valid_v[0]),
    .uart_tx_ready(ready_w[0]), .uart_tx_busy(busy_w[0]), .uart_tx_done(done_w[0]), .uart_txd(txd_w[0]));
  uart_tx_frame #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_tx_data(data), .uart_tx_valid(valid_v[1]),
    .uart_tx_ready(ready_w[1]), .uart_tx_busy(busy_w[1]), .uart_tx_done(done_w[1]), .uart_txd(txd_w[1]));
  uart_tx_frame #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_tx_data(data), .uart_tx_valid(valid_v[2]),
    .uart_tx_ready(ready_w[2]), .uart_tx_busy(busy_w[2]), .uart_tx_done(done_w[2]), .uart_txd(txd_w[2]));
  uart_tx_frame #(.CLK_FRE(1_000_000), .BPS(100_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_tx_data(data[6:0]), .uart_tx_valid(valid_v[3]),
    .uart_tx_ready(ready_w[3]), .uart_tx_busy(busy_w[3]), .uart_tx_done(done_w[3]), .uart_txd(txd_w[3]));

  logic txd_m, ready_m, busy_m, done_m;
  always_comb begin
    txd_m   = txd_w[sel];
    ready_m = ready_w[sel];
    busy_m  = busy_w[sel];
    done_m  = done_w[sel];
  end

  task automatic push_frame(input logic [8:0] d, input int nbits, input int par, input int stop);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(d[i]);
      ones += d[i];
    end
    if (par == 2) exp_q.push_back(bit'(ones % 2));
    if (par == 1) exp_q.push_back(bit'(1 - ones % 2));
    for (int i = 0; i < stop; i++) exp_q.push_back(1'b1);
  endtask

  task automatic send(input int s, input logic [7:0] d, output bit ok);
    sel = s;
    @(negedge sys_clk);
    data    = d;
    valid_v = 4'(1 << s);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready_m) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout dut=%0d ready=%b required=1", s, ready_m);
      valid_v = 4'b0000;
      exp_q.delete();
    end else begin
      @(posedge sys_clk);
    end
  endtask

  // mode 0: drop valid after accept; 1: hold valid, change data at accept+5; 2: pulse 0xFF while busy
  task automatic check_frame(input int mode, input string name, output int done_at);
    int j = 0;
    int n = exp_q.size();
    bit e;
    for (int b = 0; b < n; b++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < 10; c++) begin
        @(negedge sys_clk);
        if (j == 0 && mode != 1) valid_v = 4'b0000;
        if (mode == 1 && j == 5) data = 8'hAA;
        if (mode == 2 && j == 20) begin
          valid_v = 4'(1 << sel);
          data    = 8'hFF;
        end
        if (mode == 2 && j == 23) valid_v = 4'b0000;
        total++;
        if (txd_m !== e) begin
          bad++;
          $display("FAIL %s_txd cyc=%0d txd=%b required=%b", name, j, txd_m, e);
        end
        total++;
        if ({done_m, ready_m, busy_m} !== 3'b001) begin
          bad++;
          $display("FAIL %s_flags cyc=%0d done/ready/busy=%b required=001", name, j, {done_m, ready_m, busy_m});
        end
        j++;
      end
    end
    @(negedge sys_clk);
    done_at = cyc;
    total++;
    if ({done_m, ready_m, busy_m, txd_m} !== 4'b1101) begin
      bad++;
      $display("FAIL %s_end cyc=%0d done/ready/busy/txd=%b required=1101", name, j, {done_m, ready_m, busy_m, txd_m});
    end
  endtask

  task automatic check_idle(input int ncyc, input string name);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge sys_clk);
      total++;
      if ({done_m, ready_m, busy_m, txd_m} !== 4'b0101) begin
        bad++;
        $display("FAIL %s cyc=%0d done/ready/busy/txd=%b required=0101", name, i, {done_m, ready_m, busy_m, txd_m});
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      @(negedge sys_clk);
      total++;
      if ({done_m, ready_m, busy_m, txd_m} !== 4'b0101) begin
        bad++;
        $display("FAIL reset dut=%0d done/ready/busy/txd=%b required=0101", s, {done_m, ready_m, busy_m, txd_m});
      end
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_8n1();
    bit ok; int d;
    push_frame(9'h0A5, 8, 0, 1);
    send(0, 8'hA5, ok);
    if (ok) check_frame(0, "8n1_a5", d);
    check_idle(3, "8n1_idle");
  endtask

  task automatic test_parity();
    bit ok; int d;
    push_frame(9'h007, 8, 2, 1);
    send(1, 8'h07, ok);
    if (ok) check_frame(0, "8e1_07", d);
    push_frame(9'h007, 8, 1, 1);
    send(2, 8'h07, ok);
    if (ok) check_frame(0, "8o1_07", d);
    push_frame(9'h0C3, 8, 1, 1);
    send(2, 8'hC3, ok);
    if (ok) check_frame(0, "8o1_c3", d);
  endtask

  task automatic test_7n2();
    bit ok; int d;
    push_frame(9'h041, 7, 0, 2);
    send(3, 8'hC1, ok);
    if (ok) check_frame(0, "7n2_41", d);
    check_idle(3, "7n2_idle");
  endtask

  task automatic test_back_to_back();
    bit ok; int d1, d2;
    push_frame(9'h055, 8, 0, 1);
    send(0, 8'h55, ok);
    if (ok) begin
      check_frame(1, "b2b_55", d1);
      push_frame(9'h0AA, 8, 0, 1);
      @(posedge sys_clk);
      check_frame(0, "b2b_aa", d2);
      total++;
      if (d2 - d1 !== 101) begin
        bad++;
        $display("FAIL b2b_done_gap gap=%0d required=101", d2 - d1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int d;
    send(0, 8'h3C, ok);
    if (ok) begin
      repeat (35) @(negedge sys_clk);
      valid_v = 4'b0000;
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      total++;
      if ({done_m, ready_m, busy_m, txd_m} !== 4'b0101) begin
        bad++;
        $display("FAIL mid_reset done/ready/busy/txd=%b required=0101", {done_m, ready_m, busy_m, txd_m});
      end
      check_idle(120, "mid_reset_quiet");
    end
    push_frame(9'h03C, 8, 0, 1);
    send(0, 8'h3C, ok);
    if (ok) check_frame(0, "resend_3c", d);
  endtask

  task automatic test_ignored_valid();
    bit ok; int d;
    push_frame(9'h012, 8, 0, 1);
    send(0, 8'h12, ok);
    if (ok) check_frame(2, "busy_pulse", d);
    check_idle(120, "busy_pulse_idle");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignored_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
